settle_flow_ctrl: RTL and testbench
===================================

Name: settle_flow_ctrl

Overview:
Parametrised game-flow controller for the VGA game. It sequences MENU, PLAY, PAUSE and SETTLE. In SETTLE it enforces a minimum display time before a press is accepted, and it returns to MENU automatically after a timeout. It also latches the final score and maintains the best score across rounds. It sits between the debounced button/game-logic signals and the renderer, which selects a screen from `state`.

Parameters:
- HOLD_FRAMES, 60: frames SETTLE must be shown before a press can leave it (≥1).
- TIMEOUT_FRAMES, 600: frames after which SETTLE auto-returns to MENU (> HOLD_FRAMES).
- CNT_W, 10: width of the settle frame counter (2^CNT_W > TIMEOUT_FRAMES).
- SCORE_W, 16: score width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per VGA frame.
- btn  in  1  debounced button level, 1 = held.
- game_over  in  1  level from game logic, meaningful in PLAY only.
- score  in  SCORE_W  current score from game logic.
- state  out  2  MENU=00, PLAY=01, SETTLE=10, PAUSE=11.
- state_enter  out  1  one-cycle pulse in the first cycle of any new state.
- settle_score  out  SCORE_W  score latched on entry to SETTLE.
- best_score  out  SCORE_W  highest settle_score since reset.
- new_record  out  1  high while in SETTLE if this round set a new best.
- settle_frames  out  CNT_W  frames elapsed in current SETTLE.

Behaviour:
- Reset (async, rstn=0):
  - state=MENU; state_enter=0; settle_score=0; best_score=0; new_record=0; settle_frames=0.
  - btn_d=1, so a button held through reset produces no press.
- Press detection:
  - press = btn & ~btn_d, with btn_d registered every cycle.
  - Exactly one press per rising edge; holding the button generates nothing further.
- Transitions:
  - All transitions are evaluated on registered inputs, and `state` updates on the next clk edge (1-cycle latency).
  - MENU → PLAY on press.
  - PLAY → SETTLE on game_over. If press and game_over occur in the same cycle, game_over wins.
  - PLAY → PAUSE on press (game_over=0).
  - PAUSE → PLAY on press. game_over is ignored in PAUSE.
  - SETTLE → MENU on press only if settle_frames ≥ HOLD_FRAMES; an earlier press is discarded, not queued.
  - SETTLE → MENU on timeout: frame_tick while settle_frames == TIMEOUT_FRAMES-1. Timeout and press in the same cycle give a single transition.
- Settle counter:
  - Cleared in the cycle SETTLE is entered.
  - Increments on each frame_tick while in SETTLE.
  - Holds its value outside SETTLE.
  - A press coinciding with the frame_tick that reaches HOLD_FRAMES is judged on the pre-increment value, so it is rejected.
- Score latch on entry to SETTLE (same edge as the state update):
  - settle_score ← score.
  - If score > best_score (unsigned, strict): best_score ← score and new_record ← 1; otherwise new_record ← 0.
  - A tie is not a record.
  - new_record clears when leaving SETTLE.
  - best_score only changes at SETTLE entry or on reset.
- state_enter:
  - High for exactly the cycle in which `state` first holds its new value.
  - Never asserted after reset.
- Reset mid-SETTLE returns everything to reset values immediately; best_score is lost.

Decomposition:
- Shared package `game_pkg`: state encodings MENU/PLAY/SETTLE/PAUSE (2-bit localparams/typedef), reused by the renderer and game logic.
- Natural sub-module `edge_detect` (rising-edge pulse with configurable reset value of the delayed register), reused for other buttons.

Test Plan (HOLD_FRAMES=3, TIMEOUT_FRAMES=8, SCORE_W=8):
1. Reset with btn=1, then release and press → no transition while held; the press after release moves MENU→PLAY one cycle later, with state_enter=1 for one cycle.
2. PLAY: press → PAUSE; game_over=1 in PAUSE → stays PAUSE; press → PLAY; game_over=1 together with press → SETTLE (not PAUSE).
3. Enter SETTLE with score=50, best=0 → settle_score=50, best_score=50, new_record=1. Next round score=50 → new_record=0, best unchanged. Score=70 → best=70, new_record=1.
4. In SETTLE:
   - press at settle_frames=1 → ignored.
   - press coincident with the tick taking 2→3 → ignored.
   - press at settle_frames=3 → MENU; new_record=0.
5. SETTLE with no press: after the 8th frame_tick → MENU, settle_frames holds 7, state_enter pulses once.
6. Assert rstn=0 mid-SETTLE with best_score=70 → all outputs are 0 and state=MENU asynchronously, before the next clk edge.

Source files
------------

// File: rtl/game_pkg.sv
// Game-flow state encodings shared by the flow controller, renderer and game logic.
// The encodings are fixed because the renderer decodes `state` directly.
package game_pkg;

  typedef logic [1:0] game_state_t;

  localparam game_state_t ST_MENU   = 2'b00;
  localparam game_state_t ST_PLAY   = 2'b01;
  localparam game_state_t ST_SETTLE = 2'b10;
  localparam game_state_t ST_PAUSE  = 2'b11;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator with a configurable reset value for the delay register.
// A reset value of 1 suppresses a spurious edge from a level that is held through reset.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_q <= RST_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/settle_flow_ctrl.sv
// Game-flow controller: MENU/PLAY/PAUSE/SETTLE sequencing, settle hold and timeout,
// and latching of the final score and the best score.
module settle_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned TIMEOUT_FRAMES = 600,
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned SCORE_W        = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic               btn,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               state_enter,
  output logic [SCORE_W-1:0] settle_score,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_record,
  output logic [CNT_W-1:0]   settle_frames
);

  localparam logic [CNT_W-1:0] HOLD_C     = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(TIMEOUT_FRAMES - 1);

  game_state_t        state_q, state_d;
  logic               state_enter_q, state_enter_d;
  logic [SCORE_W-1:0] settle_score_q, settle_score_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic               new_record_q, new_record_d;
  logic [CNT_W-1:0]   settle_frames_q, settle_frames_d;

  logic press;
  logic hold_done;
  logic timeout;
  logic enter_settle;
  logic in_settle;

  edge_detect #(.RST_VAL(1'b1)) u_btn_edge (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn),
    .rise (press)
  );

  assign in_settle = (state_q == ST_SETTLE);
  // Both are judged on the pre-increment count, so a press on the tick that reaches
  // HOLD_FRAMES is still too early.
  assign hold_done = (settle_frames_q >= HOLD_C);
  assign timeout   = frame_tick && (settle_frames_q == TO_LAST_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MENU:   if (press) state_d = ST_PLAY;
      ST_PLAY: begin
        if (game_over)  state_d = ST_SETTLE;
        else if (press) state_d = ST_PAUSE;
      end
      ST_PAUSE:  if (press) state_d = ST_PLAY;
      ST_SETTLE: if ((press && hold_done) || timeout) state_d = ST_MENU;
    endcase
  end

  assign enter_settle = (state_d == ST_SETTLE) && !in_settle;

  always_comb begin
    state_enter_d   = (state_d != state_q);
    settle_score_d  = settle_score_q;
    best_score_d    = best_score_q;
    new_record_d    = new_record_q;
    settle_frames_d = settle_frames_q;
    if (enter_settle) begin
      settle_frames_d = '0;
      settle_score_d  = score;
      new_record_d    = (score > best_score_q);
      if (score > best_score_q) best_score_d = score;
    end else if (in_settle) begin
      // The count freezes on the exit edge so the final value stays visible in MENU.
      if (state_d != ST_SETTLE) new_record_d = 1'b0;
      else if (frame_tick)      settle_frames_d = settle_frames_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_MENU;
      state_enter_q   <= 1'b0;
      settle_score_q  <= '0;
      best_score_q    <= '0;
      new_record_q    <= 1'b0;
      settle_frames_q <= '0;
    end else begin
      state_q         <= state_d;
      state_enter_q   <= state_enter_d;
      settle_score_q  <= settle_score_d;
      best_score_q    <= best_score_d;
      new_record_q    <= new_record_d;
      settle_frames_q <= settle_frames_d;
    end
  end

  assign state         = state_q;
  assign state_enter   = state_enter_q;
  assign settle_score  = settle_score_q;
  assign best_score    = best_score_q;
  assign new_record    = new_record_q;
  assign settle_frames = settle_frames_q;

endmodule

// File: tb/tb_settle_flow_ctrl.sv
// Bench for settle_flow_ctrl: directed scenarios plus a randomized run against a rule-level model.
module tb_settle_flow_ctrl;

  localparam int HOLD    = 3;
  localparam int TIMEOUT = 8;
  localparam int CW      = 4;
  localparam int SW      = 8;

  localparam logic [1:0] S_MENU   = 2'b00;
  localparam logic [1:0] S_PLAY   = 2'b01;
  localparam logic [1:0] S_SETTLE = 2'b10;
  localparam logic [1:0] S_PAUSE  = 2'b11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_tick, btn, game_over;
  logic [SW-1:0] score;
  logic [1:0]    state;
  logic          state_enter, new_record;
  logic [SW-1:0] settle_score, best_score;
  logic [CW-1:0] settle_frames;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [1:0]    m_state;
  logic          m_btn_prev, m_enter, m_rec;
  int            m_frames;
  logic [SW-1:0] m_settle, m_best;

  settle_flow_ctrl #(
    .HOLD_FRAMES(HOLD), .TIMEOUT_FRAMES(TIMEOUT), .CNT_W(CW), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .btn(btn), .game_over(game_over),
    .score(score), .state(state), .state_enter(state_enter), .settle_score(settle_score),
    .best_score(best_score), .new_record(new_record), .settle_frames(settle_frames)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_MENU; m_btn_prev = 1'b1; m_enter = 1'b0; m_rec = 1'b0;
    m_frames = 0; m_settle = '0; m_best = '0;
  endtask

  // One clock edge of the game-flow rules, applied to the inputs present at that edge.
  task automatic model_step();
    logic press;
    logic [1:0] nxt;
    press = btn && !m_btn_prev;
    m_btn_prev = btn;
    nxt = m_state;
    if (m_state == S_MENU && press) nxt = S_PLAY;
    else if (m_state == S_PLAY && game_over) nxt = S_SETTLE;
    else if (m_state == S_PLAY && press) nxt = S_PAUSE;
    else if (m_state == S_PAUSE && press) nxt = S_PLAY;
    else if (m_state == S_SETTLE &&
             ((press && m_frames >= HOLD) || (frame_tick && m_frames == TIMEOUT - 1))) nxt = S_MENU;
    m_enter = (nxt != m_state);
    if (nxt == S_SETTLE && m_state != S_SETTLE) begin
      m_frames = 0;
      m_settle = score;
      m_rec = (score > m_best);
      if (m_rec) m_best = score;
    end else if (m_state == S_SETTLE) begin
      if (nxt != S_SETTLE) m_rec = 1'b0;
      else if (frame_tick) m_frames++;
    end
    m_state = nxt;
  endtask

  // Called at a negedge; drives inputs, advances one posedge, returns at the next negedge.
  task automatic tick(input logic b, input logic go, input logic ft, input logic [SW-1:0] sc);
    btn = b; game_over = go; frame_tick = ft; score = sc;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic b);
    btn = b; game_over = 1'b0; frame_tick = 1'b0; score = '0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic enter_round(input logic [SW-1:0] sc);
    tick(1'b0, 1'b0, 1'b0, sc);
    tick(1'b1, 1'b0, 1'b0, sc);
    tick(1'b0, 1'b1, 1'b0, sc);
  endtask

  task automatic leave_settle();
    repeat (HOLD) tick(1'b0, 1'b0, 1'b1, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(1'b1);
    n_total++; if (state !== S_MENU) $display("FAIL reset_state: got %0d want %0d", state, S_MENU); else n_pass++;
    n_total++;
    if ({state_enter, new_record, settle_score, best_score, settle_frames} !== '0)
      $display("FAIL reset_outputs: got enter=%0d rec=%0d settle=%0d best=%0d frames=%0d want all 0",
               state_enter, new_record, settle_score, best_score, settle_frames);
    else n_pass++;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_MENU || state_enter !== 1'b0)
      $display("FAIL held_btn_no_press: got state=%0d enter=%0d want 0/0", state, state_enter); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_PLAY || state_enter !== 1'b1)
      $display("FAIL menu_to_play: got state=%0d enter=%0d want 1/1", state, state_enter); else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_PLAY || state_enter !== 1'b0)
      $display("FAIL enter_one_cycle: got state=%0d enter=%0d want 1/0", state, state_enter); else n_pass++;
  endtask

  task automatic test_play_pause();
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_PAUSE) $display("FAIL play_to_pause: got %0d want %0d", state, S_PAUSE); else n_pass++;
    tick(1'b0, 1'b1, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 8'd0);
    n_total++; if (state !== S_PAUSE) $display("FAIL pause_ignores_go: got %0d want %0d", state, S_PAUSE); else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_PLAY) $display("FAIL pause_to_play: got %0d want %0d", state, S_PLAY); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    n_total++; if (state !== S_SETTLE) $display("FAIL go_beats_press: got %0d want %0d", state, S_SETTLE); else n_pass++;
    n_total++; if (new_record !== 1'b0) $display("FAIL tie_zero_no_record: got %0d want 0", new_record); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_scores();
    do_reset(1'b0);
    enter_round(8'd50);
    n_total++; if (settle_score !== 8'd50 || best_score !== 8'd50 || new_record !== 1'b1)
      $display("FAIL round1_score: got settle=%0d best=%0d rec=%0d want 50/50/1", settle_score, best_score, new_record);
    else n_pass++;
    leave_settle();
    enter_round(8'd50);
    n_total++; if (settle_score !== 8'd50 || best_score !== 8'd50 || new_record !== 1'b0)
      $display("FAIL tie_no_record: got settle=%0d best=%0d rec=%0d want 50/50/0", settle_score, best_score, new_record);
    else n_pass++;
    leave_settle();
    enter_round(8'd70);
    n_total++; if (settle_score !== 8'd70 || best_score !== 8'd70 || new_record !== 1'b1)
      $display("FAIL round3_record: got settle=%0d best=%0d rec=%0d want 70/70/1", settle_score, best_score, new_record);
    else n_pass++;
  endtask

  task automatic test_settle_hold();
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_SETTLE || settle_frames !== 4'd1)
      $display("FAIL early_press: got state=%0d frames=%0d want 2/1", state, settle_frames); else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    tick(1'b1, 1'b0, 1'b1, 8'd0);
    n_total++; if (state !== S_SETTLE || settle_frames !== 4'd3)
      $display("FAIL press_on_hold_tick: got state=%0d frames=%0d want 2/3", state, settle_frames); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    n_total++; if (state !== S_MENU || new_record !== 1'b0 || state_enter !== 1'b1 || best_score !== 8'd70)
      $display("FAIL hold_press_exit: got state=%0d rec=%0d enter=%0d best=%0d want 0/0/1/70",
               state, new_record, state_enter, best_score);
    else n_pass++;
  endtask

  task automatic test_timeout();
    enter_round(8'd10);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick(1'b0, 1'b0, 1'b1, 8'd0);
      tick(1'b0, 1'b0, 1'b0, 8'd0);
    end
    n_total++; if (state !== S_SETTLE || settle_frames !== 4'd7)
      $display("FAIL before_timeout: got state=%0d frames=%0d want 2/7", state, settle_frames); else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    n_total++; if (state !== S_MENU || settle_frames !== 4'd7 || state_enter !== 1'b1)
      $display("FAIL timeout_exit: got state=%0d frames=%0d enter=%0d want 0/7/1", state, settle_frames, state_enter);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    n_total++; if (state !== S_MENU || settle_frames !== 4'd7 || state_enter !== 1'b0)
      $display("FAIL after_timeout: got state=%0d frames=%0d enter=%0d want 0/7/0", state, settle_frames, state_enter);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    enter_round(8'd5);
    n_total++; if (state !== S_SETTLE || best_score !== 8'd70)
      $display("FAIL pre_reset: got state=%0d best=%0d want 2/70", state, best_score); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if ({state, state_enter, new_record, settle_score, best_score, settle_frames} !== '0)
      $display("FAIL async_reset: got state=%0d enter=%0d rec=%0d settle=%0d best=%0d frames=%0d want all 0",
               state, state_enter, new_record, settle_score, best_score, settle_frames);
    else n_pass++;
    @(negedge clk);
    do_reset(1'b0);
  endtask

  task automatic test_random();
    logic b;
    b = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) b = ~b;
      tick(b, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, SW'($urandom_range(0, 255)));
      n_total++;
      if (state !== m_state || state_enter !== m_enter || new_record !== m_rec ||
          settle_score !== m_settle || best_score !== m_best || settle_frames !== CW'(m_frames)) begin
        $display("FAIL random_cycle_%0d: got st=%0d en=%0d rec=%0d ss=%0d best=%0d fr=%0d want st=%0d en=%0d rec=%0d ss=%0d best=%0d fr=%0d",
                 i, state, state_enter, new_record, settle_score, best_score, settle_frames,
                 m_state, m_enter, m_rec, m_settle, m_best, m_frames);
      end else n_pass++;
    end
  endtask

  initial begin
    rstn = 1'b0; btn = 1'b1; game_over = 1'b0; frame_tick = 1'b0; score = '0;
    model_reset();
    test_reset();
    test_play_pause();
    test_scores();
    test_settle_hold();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
